// File: rtl/sram_pkg.sv
// Shared defaults and state encoding for the asynchronous SRAM controller.
package sram_pkg;

    localparam int SRAM_ADDR_W = 21;
    localparam int SRAM_DATA_W = 8;

    // Wide enough for WAIT_CYCLES-1 over the whole legal range 1..15.
    localparam int WAIT_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

endpackage

// File: rtl/sram_ctrl.sv
// Single-transfer asynchronous SRAM controller: SETUP, WAIT_CYCLES x ACCESS, DONE.
// Latency: rsp_valid 2+WAIT_CYCLES cycles after acceptance; next accept 3+WAIT_CYCLES after the last.
// Backpressure: req_ready only in IDLE; a pending req_valid simply waits there.
module sram_ctrl
    import sram_pkg::*;
#(
    parameter int ADDR_W      = SRAM_ADDR_W,
    parameter int DATA_W      = SRAM_DATA_W,
    parameter int WAIT_CYCLES = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              cs,
    output logic              rd,
    output logic              wr,
    output logic [ADDR_W-1:0] addr,
    inout  wire  [DATA_W-1:0] data
);

    state_t              state;
    logic                we_q;
    logic [DATA_W-1:0]   wdata_q;
    logic [WAIT_W-1:0]   wait_cnt;

    // Gated by rst_n so upstream never sees ready while reset is held.
    assign req_ready = rst_n && (state == ST_IDLE);

    // DONE always releases the bus, giving the SRAM a turnaround cycle.
    assign data = (state == ST_ACCESS && we_q) ? wdata_q : {DATA_W{1'bz}};

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            we_q      <= 1'b0;
            wdata_q   <= '0;
            wait_cnt  <= '0;
            addr      <= '0;
            cs        <= 1'b0;
            rd        <= 1'b0;
            wr        <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    rsp_valid <= 1'b0;
                    rd        <= 1'b0;
                    wr        <= 1'b0;
                    if (req_valid) begin
                        we_q    <= req_we;
                        wdata_q <= req_wdata;
                        addr    <= req_addr;
                        cs      <= 1'b1;
                        state   <= ST_SETUP;
                    end else begin
                        cs <= 1'b0;
                    end
                end

                ST_SETUP: begin
                    rd       <= ~we_q;
                    wr       <= we_q;
                    wait_cnt <= WAIT_W'(WAIT_CYCLES - 1);
                    state    <= ST_ACCESS;
                end

                ST_ACCESS: begin
                    if (wait_cnt == '0) begin
                        cs        <= 1'b0;
                        rd        <= 1'b0;
                        wr        <= 1'b0;
                        rsp_valid <= 1'b1;
                        if (!we_q) begin
                            rsp_rdata <= data;
                        end
                        state <= ST_DONE;
                    end else begin
                        wait_cnt <= wait_cnt - 1'b1;
                    end
                end

                ST_DONE: begin
                    rsp_valid <= 1'b0;
                    state     <= ST_IDLE;
                end

                default: begin
                    cs        <= 1'b0;
                    rd        <= 1'b0;
                    wr        <= 1'b0;
                    rsp_valid <= 1'b0;
                    state     <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sram_ctrl.sv
// Directed bench for sram_ctrl: per-cycle vector table at WAIT_CYCLES=1, hand sequences at WAIT_CYCLES=3.
module tb_sram_ctrl;

    localparam int AW = 21;
    localparam int DW = 8;
    localparam logic [7:0] IDLE_PAT = 8'h5A;

    logic clk;
    logic rst_n;

    logic          vld1, we1, rdy1, rsp1, cs1, rd1, wr1;
    logic [AW-1:0] addr_in1, addr1;
    logic [DW-1:0] wd1, rdata1;
    wire  [DW-1:0] data1;

    logic          vld3, we3, rdy3, rsp3, cs3, rd3, wr3;
    logic [AW-1:0] addr_in3, addr3;
    logic [DW-1:0] wd3, rdata3;
    wire  [DW-1:0] data3;

    int n_checks = 0;
    int n_fail   = 0;

    sram_ctrl #(.ADDR_W(AW), .DATA_W(DW), .WAIT_CYCLES(1)) u1 (
        .clk(clk), .rst_n(rst_n),
        .req_valid(vld1), .req_ready(rdy1), .req_we(we1),
        .req_addr(addr_in1), .req_wdata(wd1),
        .rsp_valid(rsp1), .rsp_rdata(rdata1),
        .cs(cs1), .rd(rd1), .wr(wr1), .addr(addr1), .data(data1)
    );

    sram_ctrl #(.ADDR_W(AW), .DATA_W(DW), .WAIT_CYCLES(3)) u3 (
        .clk(clk), .rst_n(rst_n),
        .req_valid(vld3), .req_ready(rdy3), .req_we(we3),
        .req_addr(addr_in3), .req_wdata(wd3),
        .rsp_valid(rsp3), .rsp_rdata(rdata3),
        .cs(cs3), .rd(rd3), .wr(wr3), .addr(addr3), .data(data3)
    );

    // SRAM models: write on the edge while cs&wr, drive read data while cs&rd.
    logic [7:0] mem1 [256];
    logic [7:0] mem3 [256];
    always @(posedge clk) begin
        if (cs1 && wr1) mem1[addr1[7:0]] <= data1;
        if (cs3 && wr3) mem3[addr3[7:0]] <= data3;
    end
    assign data1 = (cs1 && rd1) ? mem1[addr1[7:0]] : 8'hzz;
    assign data3 = (cs3 && rd3) ? mem3[addr3[7:0]] : 8'hzz;

    // Probe driver: fills the bus with a known pattern whenever nobody should drive it.
    // A controller driving at the wrong time corrupts the pattern.
    assign data1 = !(cs1 && (rd1 || wr1)) ? IDLE_PAT : 8'hzz;
    assign data3 = !(cs3 && (rd3 || wr3)) ? IDLE_PAT : 8'hzz;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic          rst;
        logic          vld;
        logic          we;
        logic [AW-1:0] a;
        logic [DW-1:0] wd;
        logic          rdy;
        logic          cs;
        logic          rd;
        logic          wr;
        logic          rv;
        logic [AW-1:0] ao;
        logic          bchk;
        logic [DW-1:0] bus;
        logic [DW-1:0] rdata;
    } vec_t;

    function automatic vec_t mk(input logic rst, input logic vld, input logic we,
                                input logic [AW-1:0] a, input logic [DW-1:0] wd,
                                input logic rdy, input logic cs, input logic rd,
                                input logic wr, input logic rv, input logic [AW-1:0] ao,
                                input logic bchk, input logic [DW-1:0] bus,
                                input logic [DW-1:0] rdata);
        vec_t v;
        v.rst = rst; v.vld = vld; v.we = we; v.a = a; v.wd = wd;
        v.rdy = rdy; v.cs = cs; v.rd = rd; v.wr = wr; v.rv = rv;
        v.ao = ao; v.bchk = bchk; v.bus = bus; v.rdata = rdata;
        return v;
    endfunction

    // Sequence on u3 at WAIT_CYCLES=3; k counts cycles after the acceptance edge.
    task automatic run3(input logic we, input logic [7:0] wd, input logic [7:0] exp_bus,
                        output int strobe_n, output int rsp_at,
                        output logic [7:0] rdata_at, output int bus_bad, output int both);
        strobe_n = 0; rsp_at = 0; rdata_at = 8'h00; bus_bad = 0; both = 0;
        @(negedge clk);
        vld3 = 1'b1; we3 = we; addr_in3 = 21'h10; wd3 = wd;
        chk("u3_ready_before_accept", 32'(rdy3), 32'd1);
        @(negedge clk);
        vld3 = 1'b0; we3 = 1'b0; addr_in3 = 21'h1FFFFF; wd3 = 8'hEE;
        for (int k = 1; k <= 8; k++) begin
            if (k > 1) @(negedge clk);
            if (rd3 && wr3) both++;
            if (we ? wr3 : rd3) begin
                strobe_n++;
                if (data3 !== exp_bus) bus_bad++;
            end
            if (rsp3 && rsp_at == 0) begin
                rsp_at   = k;
                rdata_at = rdata3;
            end
        end
    endtask

    vec_t tv[24];

    initial begin
        int       sn, ra, bb, bo;
        logic [7:0] rdv;
        int       acc[2];
        int       nacc;

        rst_n = 1'b0;
        vld1 = 1'b0; we1 = 1'b0; addr_in1 = '0; wd1 = '0;
        vld3 = 1'b0; we3 = 1'b0; addr_in3 = '0; wd3 = '0;

        //          rst vld we addr      wd     rdy cs rd wr rv  addr_o   bchk bus    rdata
        tv[0]  = mk(0, 0, 0, 21'h0,   8'h00, 0, 0, 0, 0, 0, 21'h0,   1, 8'h5A, 8'h00);
        tv[1]  = mk(0, 0, 0, 21'h0,   8'h00, 0, 0, 0, 0, 0, 21'h0,   1, 8'h5A, 8'h00);
        tv[2]  = mk(0, 0, 0, 21'h0,   8'h00, 0, 0, 0, 0, 0, 21'h0,   1, 8'h5A, 8'h00);
        tv[3]  = mk(1, 0, 0, 21'h0,   8'h00, 1, 0, 0, 0, 0, 21'h0,   1, 8'h5A, 8'h00);
        tv[4]  = mk(1, 1, 1, 21'hA5,  8'h3C, 0, 1, 0, 0, 0, 21'hA5,  0, 8'h00, 8'h00);
        tv[5]  = mk(1, 0, 0, 21'h1FF, 8'hFF, 0, 1, 0, 1, 0, 21'hA5,  1, 8'h3C, 8'h00);
        tv[6]  = mk(1, 0, 0, 21'h0,   8'h00, 0, 0, 0, 0, 1, 21'hA5,  1, 8'h5A, 8'h00);
        tv[7]  = mk(1, 0, 0, 21'h0,   8'h00, 1, 0, 0, 0, 0, 21'hA5,  1, 8'h5A, 8'h00);
        tv[8]  = mk(1, 1, 0, 21'hA5,  8'h00, 0, 1, 0, 0, 0, 21'hA5,  0, 8'h00, 8'h00);
        tv[9]  = mk(1, 1, 1, 21'h77,  8'h99, 0, 1, 1, 0, 0, 21'hA5,  1, 8'h3C, 8'h00);
        tv[10] = mk(1, 1, 1, 21'h77,  8'h99, 0, 0, 0, 0, 1, 21'hA5,  1, 8'h5A, 8'h3C);
        tv[11] = mk(1, 1, 1, 21'h77,  8'h99, 1, 0, 0, 0, 0, 21'hA5,  1, 8'h5A, 8'h3C);
        tv[12] = mk(1, 1, 1, 21'h77,  8'h99, 0, 1, 0, 0, 0, 21'h77,  0, 8'h00, 8'h3C);
        tv[13] = mk(1, 0, 0, 21'h0,   8'h00, 0, 1, 0, 1, 0, 21'h77,  1, 8'h99, 8'h3C);
        tv[14] = mk(1, 0, 0, 21'h0,   8'h00, 0, 0, 0, 0, 1, 21'h77,  1, 8'h5A, 8'h3C);
        tv[15] = mk(1, 0, 0, 21'h0,   8'h00, 1, 0, 0, 0, 0, 21'h77,  1, 8'h5A, 8'h3C);
        tv[16] = mk(1, 1, 1, 21'h55,  8'h66, 0, 1, 0, 0, 0, 21'h55,  0, 8'h00, 8'h3C);
        tv[17] = mk(1, 0, 0, 21'h0,   8'h00, 0, 1, 0, 1, 0, 21'h55,  1, 8'h66, 8'h3C);
        tv[18] = mk(0, 0, 0, 21'h0,   8'h00, 0, 0, 0, 0, 0, 21'h0,   1, 8'h5A, 8'h00);
        tv[19] = mk(1, 0, 0, 21'h0,   8'h00, 1, 0, 0, 0, 0, 21'h0,   1, 8'h5A, 8'h00);
        tv[20] = mk(1, 1, 0, 21'h77,  8'h00, 0, 1, 0, 0, 0, 21'h77,  0, 8'h00, 8'h00);
        tv[21] = mk(1, 0, 0, 21'h0,   8'h00, 0, 1, 1, 0, 0, 21'h77,  1, 8'h99, 8'h00);
        tv[22] = mk(1, 0, 0, 21'h0,   8'h00, 0, 0, 0, 0, 1, 21'h77,  1, 8'h5A, 8'h99);
        tv[23] = mk(1, 0, 0, 21'h0,   8'h00, 1, 0, 0, 0, 0, 21'h77,  1, 8'h5A, 8'h99);

        for (int i = 0; i < 24; i++) begin
            @(negedge clk);
            rst_n = tv[i].rst; vld1 = tv[i].vld; we1 = tv[i].we;
            addr_in1 = tv[i].a; wd1 = tv[i].wd;
            @(posedge clk);
            #1;
            chk($sformatf("v%0d_req_ready", i), 32'(rdy1), 32'(tv[i].rdy));
            chk($sformatf("v%0d_cs", i), 32'(cs1), 32'(tv[i].cs));
            chk($sformatf("v%0d_rd", i), 32'(rd1), 32'(tv[i].rd));
            chk($sformatf("v%0d_wr", i), 32'(wr1), 32'(tv[i].wr));
            chk($sformatf("v%0d_rsp_valid", i), 32'(rsp1), 32'(tv[i].rv));
            chk($sformatf("v%0d_addr", i), 32'(addr1), 32'(tv[i].ao));
            chk($sformatf("v%0d_rsp_rdata", i), 32'(rdata1), 32'(tv[i].rdata));
            if (tv[i].bchk) chk($sformatf("v%0d_data_bus", i), 32'(data1), 32'(tv[i].bus));
        end

        // WAIT_CYCLES=3 write then read of the same location.
        run3(1'b1, 8'h42, 8'h42, sn, ra, rdv, bb, bo);
        chk("w3_wr_cycles", 32'(sn), 32'd3);
        chk("w3_rsp_cycle", 32'(ra), 32'd5);
        chk("w3_bus_value", 32'(bb), 32'd0);
        chk("w3_rd_wr_overlap", 32'(bo), 32'd0);
        chk("w3_rdata_unchanged", 32'(rdv), 32'h00);

        run3(1'b0, 8'hEE, 8'h42, sn, ra, rdv, bb, bo);
        chk("r3_rd_cycles", 32'(sn), 32'd3);
        chk("r3_rsp_cycle", 32'(ra), 32'd5);
        chk("r3_bus_value", 32'(bb), 32'd0);
        chk("r3_rd_wr_overlap", 32'(bo), 32'd0);
        chk("r3_rdata", 32'(rdv), 32'h42);

        // req_valid held high: acceptances 3+WAIT_CYCLES apart.
        nacc = 0;
        acc[0] = 0; acc[1] = 0;
        @(negedge clk);
        vld3 = 1'b1; we3 = 1'b0; addr_in3 = 21'h10;
        for (int c = 0; c < 20; c++) begin
            if (c > 0) @(negedge clk);
            if (rdy3 && nacc < 2) begin
                acc[nacc] = c;
                nacc++;
            end
        end
        vld3 = 1'b0;
        chk("b2b_accept_count", 32'(nacc), 32'd2);
        chk("b2b_accept_gap", 32'(acc[1] - acc[0]), 32'd6);
        repeat (8) @(negedge clk);
        chk("b2b_rdata", 32'(rdata3), 32'h42);
        chk("b2b_idle_ready", 32'(rdy3), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
